// File: rtl/cpu_pkg.sv
// Shared types for the processor controller: opcodes, FSM states, ALU selects
// and the bit positions of the instruction fields.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_e;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_STORE  = 4'd4,
        ST_LOAD_A = 4'd5,
        ST_LOAD_B = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RA_MSB = 11;
    localparam int RA_LSB = 8;
    localparam int RB_MSB = 7;
    localparam int RB_LSB = 4;
    localparam int RW_MSB = 3;
    localparam int RW_LSB = 0;
    localparam int DA_MSB = 11;
    localparam int DA_LSB = 4;

endpackage

// File: rtl/program_counter.sv
// Instruction address counter: increments when Inc is high, wraps at 2**PC_W,
// cleared asynchronously by Reset.
module program_counter #(
    parameter int PC_W = 7
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Inc,
    output logic [PC_W-1:0] Count
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Count <= '0;
        end else if (Inc) begin
            Count <= Count + 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FSM controller: fetches from the instruction ROM, holds PC/IR and
// drives the DataPath control inputs as Moore outputs of state and IR.
module control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = 7,
    parameter int IW   = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [IW-1:0]   IR_in,
    output logic [PC_W-1:0] PC_Addr,
    output logic [7:0]      D_Addr,
    output logic            D_wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_en,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [2:0]      Alu_s0,
    output logic [3:0]      State_out
);

    state_e        state_q;
    state_e        state_d;
    logic [IW-1:0] ir_q;
    opcode_e       op;
    logic          fetch;

    assign fetch = (state_q == ST_FETCH);
    assign op    = opcode_e'(ir_q[OP_MSB:OP_LSB]);

    program_counter #(.PC_W(PC_W)) u_pc (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (fetch),
        .Count (PC_Addr)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_INIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (fetch) begin
                ir_q <= IR_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_STORE: state_d = ST_STORE;
                    OP_LOAD:  state_d = ST_LOAD_A;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_NOOP;
                endcase
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_NOOP, ST_STORE, ST_ADD, ST_SUB, ST_LOAD_B: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    // Address fields come straight from IR; IR is cleared by Reset so they read 0 then.
    always_comb begin
        D_Addr     = ir_q[DA_MSB:DA_LSB];
        RF_Ra_addr = (op == OP_STORE) ? ir_q[RW_MSB:RW_LSB] : ir_q[RA_MSB:RA_LSB];
        RF_Rb_addr = ir_q[RB_MSB:RB_LSB];
        RF_W_addr  = ir_q[RW_MSB:RW_LSB];
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        Alu_s0     = ALU_PASS;
        if (!Reset) begin
            case (state_q)
                ST_STORE: D_wr = 1'b1;
                ST_LOAD_B: begin
                    RF_s    = 1'b1;
                    RF_W_en = 1'b1;
                end
                ST_ADD: begin
                    Alu_s0  = ALU_ADD;
                    RF_W_en = 1'b1;
                end
                ST_SUB: begin
                    Alu_s0  = ALU_SUB;
                    RF_W_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign State_out = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: instruction-level phase model checked every
// cycle, plus literal expectations at the key points of each instruction.
module tb_control_unit;
    import cpu_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] IR_in;
    logic [6:0]  PC_Addr;
    logic [7:0]  D_Addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  Alu_s0;
    logic [3:0]  State_out;

    logic [15:0] rom [128];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic        cmp_en = 1'b0;

    assign IR_in = rom[PC_Addr];

    control_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IR_in      (IR_in),
        .PC_Addr    (PC_Addr),
        .D_Addr     (D_Addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .Alu_s0     (Alu_s0),
        .State_out  (State_out)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Instruction-level model: phase 0 fetch, 1 decode, 2 execute, 3 load write-back.
    logic        m_init = 1'b1;
    int          m_phase = 0;
    logic [15:0] m_ir = 16'h0;
    logic [6:0]  m_pc = 7'd0;
    logic        m_halt = 1'b0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_init <= 1'b1; m_phase <= 0; m_ir <= 16'h0; m_pc <= 7'd0; m_halt <= 1'b0;
        end else if (m_init) begin
            m_init <= 1'b0; m_phase <= 0;
        end else if (!m_halt) begin
            if (m_phase == 0) begin
                m_ir <= rom[m_pc]; m_pc <= m_pc + 7'd1; m_phase <= 1;
            end else if (m_phase == 1) begin
                if (m_ir[15:12] == 4'd5) m_halt <= 1'b1;
                else                     m_phase <= 2;
            end else if (m_phase == 2 && m_ir[15:12] == 4'd2) begin
                m_phase <= 3;
            end else begin
                m_phase <= 0;
            end
        end
    end

    function automatic logic [36:0] model_out();
        logic [3:0] op, st, ra;
        logic       wr, rs, wen;
        logic [2:0] alu;
        op = m_ir[15:12];
        wr = 1'b0; rs = 1'b0; wen = 1'b0; alu = 3'd0;
        if (m_init)              st = ST_INIT;
        else if (m_halt)         st = ST_HALT;
        else if (m_phase == 0)   st = ST_FETCH;
        else if (m_phase == 1)   st = ST_DECODE;
        else if (m_phase == 3) begin st = ST_LOAD_B; rs = 1'b1; wen = 1'b1; end
        else if (op == 4'd1) begin st = ST_STORE; wr = 1'b1; end
        else if (op == 4'd2)     st = ST_LOAD_A;
        else if (op == 4'd3) begin st = ST_ADD; wen = 1'b1; alu = 3'd1; end
        else if (op == 4'd4) begin st = ST_SUB; wen = 1'b1; alu = 3'd2; end
        else                     st = ST_NOOP;
        ra = (op == 4'd1) ? m_ir[3:0] : m_ir[11:8];
        return {st, m_pc, m_ir[11:4], wr, rs, m_ir[3:0], wen, ra, m_ir[7:4], alu};
    endfunction

    always @(negedge Clk) begin
        if (cmp_en)
            check("cycle_model", {27'd0, State_out, PC_Addr, D_Addr, D_wr, RF_s, RF_W_addr,
                                  RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0},
                  {27'd0, model_out()});
    end

    task automatic wait_cyc(input int k);
        int guard = 0;
        while (cyc < k && guard < 2000) begin
            @(negedge Clk);
            guard++;
        end
        check("wait_cycle", cyc, k);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h2093;
        rom[1] = 16'h3125;
        rom[2] = 16'h4125;
        rom[3] = 16'h10A2;
        rom[4] = 16'hF000;
        rom[5] = 16'h5000;
        #2 Reset = 1'b1;
        repeat (2) @(negedge Clk);
        cmp_en = 1'b1;
        check("reset_outputs", {State_out, PC_Addr, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                                RF_Ra_addr, RF_Rb_addr, Alu_s0}, 37'd0);
        Reset = 1'b0;
        #1 check("init_after_release", State_out, ST_INIT);

        wait_cyc(1);
        check("first_fetch", {State_out, PC_Addr}, {ST_FETCH, 7'd0});
        wait_cyc(2);
        check("decode_pc", {State_out, PC_Addr}, {ST_DECODE, 7'd1});
        wait_cyc(3);
        check("load_a", {State_out, D_wr, RF_W_en, RF_s}, {ST_LOAD_A, 3'b000});
        wait_cyc(4);
        check("load_b", {RF_W_en, RF_s, D_wr, D_Addr, RF_W_addr}, {3'b110, 8'd9, 4'd3});
        wait_cyc(5);
        check("load_back_fetch", State_out, ST_FETCH);
        wait_cyc(7);
        check("add", {Alu_s0, RF_W_en, RF_s, RF_Ra_addr, RF_Rb_addr, RF_W_addr},
              {3'd1, 2'b10, 4'd1, 4'd2, 4'd5});
        wait_cyc(8);
        check("add_one_cycle", {RF_W_en, Alu_s0}, 4'd0);
        wait_cyc(10);
        check("sub", {Alu_s0, RF_W_en, RF_s, RF_Ra_addr, RF_Rb_addr, RF_W_addr},
              {3'd2, 2'b10, 4'd1, 4'd2, 4'd5});
        wait_cyc(13);
        check("store", {D_wr, RF_W_en, D_Addr, RF_Ra_addr}, {2'b10, 8'd10, 4'd2});
        wait_cyc(14);
        check("store_one_cycle", D_wr, 1'b0);
        wait_cyc(16);
        check("op_f_noop", {State_out, D_wr, RF_W_en, Alu_s0}, {ST_NOOP, 5'd0});
        for (int i = 0; i < 20; i++) begin
            wait_cyc(19 + i);
            check("halt_hold", {State_out, PC_Addr, D_wr, RF_W_en}, {ST_HALT, 7'd6, 2'b00});
        end

        Reset = 1'b1;
        #1 check("halt_reset", {State_out, PC_Addr, D_Addr}, {ST_INIT, 15'd0});
        @(negedge Clk);
        Reset = 1'b0;
        wait_cyc(4);
        check("pre_async_load_b", RF_W_en, 1'b1);
        #2 Reset = 1'b1;
        #1 check("async_reset_load_b", {RF_W_en, RF_s, State_out}, {2'b00, ST_INIT});

        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        @(negedge Clk);
        Reset = 1'b0;
        wait_cyc(382);
        check("pc_127", {State_out, PC_Addr}, {ST_FETCH, 7'd127});
        wait_cyc(383);
        check("pc_wrap", {State_out, PC_Addr}, {ST_DECODE, 7'd0});

        @(negedge Clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
